// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake states, word type and the arbiter FSM encoding.
package cpu_types_pkg;
  localparam int CPUS_MAX = 8;
  localparam int WORD_BITS = 32;

  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping modulo N.
module rr_pick
  import cpu_types_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    // scan from the far end so the nearest candidate is the one left standing
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
  end
endmodule

// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between CPUS cores (icache + dcache each).
// Optional per-core grant/stall counters with ARB_PERF_CNT_EN.
module multicore_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS*WORD_W-1:0] dload,
  input  ramstate_t              ramstate,
  input  logic [WORD_W-1:0]      ramload,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic                   ram_err
`ifdef ARB_PERF_CNT_EN
  ,output logic [CPUS*64-1:0]    perf_cnt
`endif
);
  localparam int PW = ptr_w(CPUS);

  arb_state_t                  state;
  logic [PW-1:0]               rr_ptr, gidx, pick_idx, rr_next;
  logic                        gdata, pick_vld;
  logic [CPUS-1:0]             dreq, creq;
  logic [CPUS-1:0][WORD_W-1:0] ia, da, ds;
  logic                        busy, act, done, err;

  assign ia   = iaddr;
  assign da   = daddr;
  assign ds   = dstore;
  assign dreq = dREN | dWEN;
  assign creq = dreq | iREN;

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

  rr_pick #(.N(CPUS)) u_pick (
    .req   (creq),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // reset masks the outputs in the same cycle it is asserted
  assign busy    = (state == ARB_GRANT) && !RST;
  assign act     = gdata ? dreq[gidx] : iREN[gidx];
  assign done    = busy && act && (ramstate == ACCESS);
  assign err     = busy && act && (ramstate == ERROR);
  assign rr_next = (int'(gidx) == CPUS - 1) ? '0 : gidx + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      gidx   <= '0;
      gdata  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            gidx  <= pick_idx;
            gdata <= dreq[pick_idx];
            state <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (!act) begin
            state <= ARB_IDLE;
          end else if (ramstate == ACCESS) begin
            state  <= ARB_IDLE;
            rr_ptr <= rr_next;
          end else if (ramstate == ERROR) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iwait    = '1;
    dwait    = '1;
    ram_err  = err;
    if (busy) begin
      if (gdata) begin
        ramaddr  = da[gidx];
        ramstore = ds[gidx];
        ramWEN   = dWEN[gidx];
        ramREN   = dREN[gidx] & ~dWEN[gidx];
      end else begin
        ramaddr = ia[gidx];
        ramREN  = iREN[gidx];
      end
    end
    if (done) begin
      if (gdata) dwait[gidx] = 1'b0;
      else       iwait[gidx] = 1'b0;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [CPUS-1:0][31:0] gcnt, scnt;

  for (genvar k = 0; k < CPUS; k++) begin : g_cnt
    always_ff @(posedge CLK) begin
      if (RST) begin
        gcnt[k] <= '0;
        scnt[k] <= '0;
      end else begin
        if (done && gidx == PW'(k) && gcnt[k] != '1) gcnt[k] <= gcnt[k] + 1'b1;
        if (busy && creq[k] && gidx != PW'(k) && scnt[k] != '1) scnt[k] <= scnt[k] + 1'b1;
      end
    end
    assign perf_cnt[k*64 +: 64] = {gcnt[k], scnt[k]};
  end
`endif
endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Directed self-checking bench for multicore_mem_arbiter (CPUS=2, WORD_W=32).
module tb_multicore_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;
  localparam int W    = 32;

  logic            CLK = 1'b0;
  logic            RST;
  logic [CPUS-1:0] iREN, dREN, dWEN;
  logic [CPUS*W-1:0] iaddr, daddr, dstore;
  logic [CPUS-1:0] iwait, dwait;
  logic [CPUS*W-1:0] iload, dload;
  ramstate_t       ramstate;
  logic [W-1:0]    ramload, ramaddr, ramstore;
  logic            ramREN, ramWEN, ram_err;
`ifdef ARB_PERF_CNT_EN
  logic [CPUS*64-1:0] perf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  multicore_mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramstate(ramstate), .ramload(ramload), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramREN(ramREN), .ramWEN(ramWEN), .ram_err(ram_err)
`ifdef ARB_PERF_CNT_EN
    ,.perf_cnt(perf_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_reset();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    iREN = 2'b11; dWEN = 2'b11; ramstate = ACCESS;
    step(); step();
    settle();
    checks++; if (iwait !== 2'b11) begin errors++; $display("FAIL reset_iwait: got %b want 11", iwait); end
    checks++; if (dwait !== 2'b11) begin errors++; $display("FAIL reset_dwait: got %b want 11", dwait); end
    checks++; if ({ramREN, ramWEN, ram_err} !== 3'b000) begin errors++; $display("FAIL reset_en: got %b want 000", {ramREN, ramWEN, ram_err}); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr %h store %h want 0 0", ramaddr, ramstore); end
    checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d want ARB_IDLE", dut.state); end
    apply_reset();
  endtask

  task automatic test_single_instr();
    apply_reset();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    iREN[0] = 1'b1; iaddr[0 +: W] = 32'h40;
    settle();
    checks++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL instr_t0: got iwait %b ren %b want 11 0", iwait, ramREN); end
    step();
    checks++; if (iwait !== 2'b10) begin errors++; $display("FAIL instr_wait: got %b want 10", iwait); end
    checks++; if (ramaddr !== 32'h40 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL instr_bus: got addr %h ren %b wen %b want 40 1 0", ramaddr, ramREN, ramWEN); end
    checks++; if (iload[0 +: W] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL instr_load: got %h want deadbeef", iload[0 +: W]); end
    checks++; if (dwait !== 2'b11) begin errors++; $display("FAIL instr_dwait: got %b want 11", dwait); end
    step();
    iREN = '0;
    settle();
    checks++; if (iwait !== 2'b11 || dut.rr_ptr !== 1'b1) begin errors++; $display("FAIL instr_after: got iwait %b rr %b want 11 1", iwait, dut.rr_ptr); end
  endtask

  task automatic test_data_priority();
    apply_reset();
    ramstate = BUSY;
    iREN[0] = 1'b1; dREN[0] = 1'b1;
    iaddr[0 +: W] = 32'h40; daddr[0 +: W] = 32'h100;
    step();
    checks++; if (ramaddr !== 32'h100 || ramREN !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL prio_bus: got addr %h ren %b wen %b want 100 1 0", ramaddr, ramREN, ramWEN); end
    checks++; if (dwait !== 2'b11 || iwait !== 2'b11) begin errors++; $display("FAIL prio_busy: got d %b i %b want 11 11", dwait, iwait); end
    ramstate = ACCESS;
    settle();
    checks++; if (dwait !== 2'b10 || iwait !== 2'b11) begin errors++; $display("FAIL prio_done: got d %b i %b want 10 11", dwait, iwait); end
    step();
    dREN = '0;
    settle();
    checks++; if (dut.state !== ARB_IDLE || iwait !== 2'b11) begin errors++; $display("FAIL prio_gap: got state %0d iwait %b want 0 11", dut.state, iwait); end
    step();
    checks++; if (ramaddr !== 32'h40 || ramREN !== 1'b1 || iwait !== 2'b10) begin errors++; $display("FAIL prio_instr: got addr %h ren %b iwait %b want 40 1 10", ramaddr, ramREN, iwait); end
    step();
    iREN = '0;
  endtask

  task automatic test_back_to_back();
    logic [1:0][W-1:0] ea, es;
    int c;
    apply_reset();
    ea[0] = 32'h200; ea[1] = 32'h300;
    es[0] = 32'hA0A0_1111; es[1] = 32'hB0B0_2222;
    ramstate = ACCESS;
    dWEN = 2'b11;
    daddr = {ea[1], ea[0]};
    dstore = {es[1], es[0]};
    settle();
    for (int i = 0; i < 4; i++) begin
      c = i % 2;
      step();
      checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== ea[c] || ramstore !== es[c]) begin
        errors++; $display("FAIL b2b_bus%0d: got wen %b ren %b addr %h store %h want 1 0 %h %h", i, ramWEN, ramREN, ramaddr, ramstore, ea[c], es[c]);
      end
      checks++; if (dwait !== ~(2'b01 << c)) begin errors++; $display("FAIL b2b_wait%0d: got %b want %b", i, dwait, ~(2'b01 << c)); end
      step();
      checks++; if (dwait !== 2'b11 || ramWEN !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got dwait %b wen %b want 11 0", i, dwait, ramWEN); end
    end
    dWEN = '0;
  endtask

  task automatic test_latency3();
    apply_reset();
    ramstate = BUSY; ramload = 32'h1234_5678;
    dREN[1] = 1'b1; daddr[W +: W] = 32'h500;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (dwait !== 2'b11 || ramREN !== 1'b1 || ramaddr !== 32'h500) begin
        errors++; $display("FAIL lat3_busy%0d: got dwait %b ren %b addr %h want 11 1 500", i, dwait, ramREN, ramaddr);
      end
      step();
    end
    ramstate = ACCESS;
    settle();
    checks++; if (dwait !== 2'b01) begin errors++; $display("FAIL lat3_done: got %b want 01", dwait); end
    checks++; if (dload[W +: W] !== 32'h1234_5678) begin errors++; $display("FAIL lat3_load: got %h want 12345678", dload[W +: W]); end
    step();
    dREN = '0;
    settle();
    checks++; if (dut.rr_ptr !== 1'b0 || dut.state !== ARB_IDLE) begin errors++; $display("FAIL lat3_ptr: got rr %b state %0d want 0 0", dut.rr_ptr, dut.state); end
  endtask

  task automatic test_error();
    apply_reset();
    ramstate = ERROR;
    dREN = 2'b11; daddr = {32'h700, 32'h600};
    step();
    checks++; if (ram_err !== 1'b1 || dwait !== 2'b11 || ramaddr !== 32'h600) begin
      errors++; $display("FAIL err_pulse: got err %b dwait %b addr %h want 1 11 600", ram_err, dwait, ramaddr);
    end
    step();
    ramstate = ACCESS;
    settle();
    checks++; if (ram_err !== 1'b0 || dut.rr_ptr !== 1'b0) begin errors++; $display("FAIL err_idle: got err %b rr %b want 0 0", ram_err, dut.rr_ptr); end
    step();
    checks++; if (ramaddr !== 32'h600 || dwait !== 2'b10) begin errors++; $display("FAIL err_retry: got addr %h dwait %b want 600 10", ramaddr, dwait); end
    step();
    dREN[0] = 1'b0;
    step();
    checks++; if (ramaddr !== 32'h700 || dwait !== 2'b01) begin errors++; $display("FAIL err_next: got addr %h dwait %b want 700 01", ramaddr, dwait); end
    step();
    dREN = '0;
  endtask

  task automatic test_drop();
    apply_reset();
    ramstate = BUSY;
    dREN[1] = 1'b1; daddr[W +: W] = 32'h800;
    step();
    dREN = '0;
    ramstate = ACCESS;
    settle();
    checks++; if (dwait !== 2'b11 || ramREN !== 1'b0) begin errors++; $display("FAIL drop_wait: got dwait %b ren %b want 11 0", dwait, ramREN); end
    step();
    checks++; if (dut.state !== ARB_IDLE || dut.rr_ptr !== 1'b0) begin errors++; $display("FAIL drop_state: got state %0d rr %b want 0 0", dut.state, dut.rr_ptr); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ramstate = ACCESS;
    dREN[1] = 1'b1;
    step();
    step();
    dREN = '0;
    ramstate = BUSY;
    dWEN[0] = 1'b1; dREN[1] = 1'b1; daddr[0 +: W] = 32'h900; dstore[0 +: W] = 32'h5555_AAAA;
    step();
    step();
    checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h900) begin errors++; $display("FAIL rmid_pre: got wen %b addr %h want 1 900", ramWEN, ramaddr); end
`ifdef ARB_PERF_CNT_EN
    checks++; if (perf_cnt[63:32] !== 32'd0 || perf_cnt[127:96] !== 32'd1 || perf_cnt[95:64] !== 32'd1) begin
      errors++; $display("FAIL rmid_cnt_pre: got %h want g0=0 g1=1 s1=1", perf_cnt);
    end
`endif
    RST = 1'b1;
    step();
    RST = 1'b0;
    settle();
    checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || ramaddr !== 32'h0) begin errors++; $display("FAIL rmid_bus: got wen %b ren %b addr %h want 0 0 0", ramWEN, ramREN, ramaddr); end
    checks++; if (iwait !== 2'b11 || dwait !== 2'b11) begin errors++; $display("FAIL rmid_wait: got i %b d %b want 11 11", iwait, dwait); end
    checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL rmid_state: got %0d want ARB_IDLE", dut.state); end
`ifdef ARB_PERF_CNT_EN
    checks++; if (perf_cnt !== '0) begin errors++; $display("FAIL rmid_cnt: got %h want 0", perf_cnt); end
`endif
    dWEN = '0; dREN = '0;
  endtask

  initial begin
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
    #1;
    test_reset();
    test_single_instr();
    test_data_priority();
    test_back_to_back();
    test_latency3();
    test_error();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
